// File: rtl/mem_issue_queue.sv
// rtl/mem_issue_queue.sv - in-order load/store issue queue with ROB-ordered flush.
// Optional MEM_IQ_BYPASS_EN: an op entering an empty queue is presented to the memory stage combinationally.
`ifndef PREG_RANGE
`define PREG_RANGE 5:0
`endif
`ifndef SRC_RANGE
`define SRC_RANGE 31:0
`endif
`ifndef LS_SIZE_RANGE
`define LS_SIZE_RANGE 1:0
`endif
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 4:0
`endif

module mem_issue_queue #(
   parameter int DEPTH = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enq_valid,
   output logic                  enq_ready,
   input  logic [`PREG_RANGE]    prd,
   input  logic                  is_load,
   input  logic                  is_store,
   input  logic                  is_unsigned,
   input  logic [`SRC_RANGE]     imm,
   input  logic [`SRC_RANGE]     src1,
   input  logic [`SRC_RANGE]     src2,
   input  logic [`LS_SIZE_RANGE] ls_size,
   input  logic                  robidx_flag,
   input  logic [`ROB_SIZE_LOG]  robidx,
   output logic                  deq_valid,
   input  logic                  deq_ready,
   output logic [`PREG_RANGE]    deq_prd,
   output logic                  deq_is_load,
   output logic                  deq_is_store,
   output logic                  deq_is_unsigned,
   output logic [`SRC_RANGE]     deq_imm,
   output logic [`SRC_RANGE]     deq_src1,
   output logic [`SRC_RANGE]     deq_src2,
   output logic [`LS_SIZE_RANGE] deq_ls_size,
   output logic                  deq_robidx_flag,
   output logic [`ROB_SIZE_LOG]  deq_robidx,
   input  logic                  flush_valid,
   input  logic                  flush_robidx_flag,
   input  logic [`ROB_SIZE_LOG]  flush_robidx,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef struct packed {
      logic [`PREG_RANGE]    prd;
      logic                  is_load;
      logic                  is_store;
      logic                  is_unsigned;
      logic [`SRC_RANGE]     imm;
      logic [`SRC_RANGE]     src1;
      logic [`SRC_RANGE]     src2;
      logic [`LS_SIZE_RANGE] ls_size;
      logic                  robidx_flag;
      logic [`ROB_SIZE_LOG]  robidx;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        enq_e, head_e, out_e;
   logic [AW-1:0] head, tail, idx;
   logic [CW-1:0] count_q, keep;
   logic          run, head_killed, q_valid, deq_fire, enq_fire, bypass_taken;

   function automatic logic younger(input logic ef, input logic [`ROB_SIZE_LOG] er,
                                    input logic ff, input logic [`ROB_SIZE_LOG] fr);
      return (ff ^ ef) ^ (fr < er);
   endfunction

   assign enq_e = {prd, is_load, is_store, is_unsigned, imm, src1, src2, ls_size, robidx_flag, robidx};
   assign head_e = mem[head];
   assign head_killed = flush_valid & younger(head_e.robidx_flag, head_e.robidx,
                                              flush_robidx_flag, flush_robidx);
   assign q_valid = (count_q != '0) & ~head_killed;
   assign enq_ready = count_q < FULL;
   assign count = count_q;

`ifdef MEM_IQ_BYPASS_EN
   logic bypass;
   assign bypass = (count_q == '0) & enq_valid
                   & ~(flush_valid & younger(robidx_flag, robidx, flush_robidx_flag, flush_robidx));
   assign out_e = bypass ? enq_e : head_e;
   assign deq_valid = q_valid | bypass;
   assign bypass_taken = bypass & deq_ready;
`else
   assign out_e = head_e;
   assign deq_valid = q_valid;
   assign bypass_taken = 1'b0;
`endif

   assign deq_fire = q_valid & deq_ready;
   assign enq_fire = enq_valid & enq_ready & ~flush_valid & ~bypass_taken;

   assign deq_prd         = out_e.prd;
   assign deq_is_load     = out_e.is_load;
   assign deq_is_store    = out_e.is_store;
   assign deq_is_unsigned = out_e.is_unsigned;
   assign deq_imm         = out_e.imm;
   assign deq_src1        = out_e.src1;
   assign deq_src2        = out_e.src2;
   assign deq_ls_size     = out_e.ls_size;
   assign deq_robidx_flag = out_e.robidx_flag;
   assign deq_robidx      = out_e.robidx;

   // Surviving run length from head; the first killed entry ends it.
   always_comb begin
      keep = '0;
      run = 1'b1;
      idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + AW'(i);
         if (run && (CW'(i) < count_q)
             && !younger(mem[idx].robidx_flag, mem[idx].robidx, flush_robidx_flag, flush_robidx))
            keep = keep + CW'(1);
         else
            run = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else begin
         if (deq_fire)
            head <= head + AW'(1);
         if (flush_valid) begin
            tail    <= head + keep[AW-1:0];
            count_q <= keep - CW'(deq_fire);
         end else begin
            if (enq_fire)
               tail <= tail + AW'(1);
            count_q <= count_q + CW'(enq_fire) - CW'(deq_fire);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (enq_fire)
         mem[tail] <= enq_e;
   end
endmodule

// File: tb/tb_mem_issue_queue.sv
// tb/tb_mem_issue_queue.sv - directed self-checking bench for mem_issue_queue (DEPTH=4).
module tb_mem_issue_queue;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enq_valid, enq_ready;
   logic [5:0]  prd;
   logic        is_load, is_store, is_unsigned;
   logic [31:0] imm, src1, src2;
   logic [1:0]  ls_size;
   logic        robidx_flag;
   logic [4:0]  robidx;
   logic        deq_valid, deq_ready;
   logic [5:0]  deq_prd;
   logic        deq_is_load, deq_is_store, deq_is_unsigned;
   logic [31:0] deq_imm, deq_src1, deq_src2;
   logic [1:0]  deq_ls_size;
   logic        deq_robidx_flag;
   logic [4:0]  deq_robidx;
   logic        flush_valid, flush_robidx_flag;
   logic [4:0]  flush_robidx;
   logic [2:0]  count;
   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   mem_issue_queue #(.DEPTH(4)) dut (
      .clock(clock), .reset(reset),
      .enq_valid(enq_valid), .enq_ready(enq_ready),
      .prd(prd), .is_load(is_load), .is_store(is_store), .is_unsigned(is_unsigned),
      .imm(imm), .src1(src1), .src2(src2), .ls_size(ls_size),
      .robidx_flag(robidx_flag), .robidx(robidx),
      .deq_valid(deq_valid), .deq_ready(deq_ready),
      .deq_prd(deq_prd), .deq_is_load(deq_is_load), .deq_is_store(deq_is_store),
      .deq_is_unsigned(deq_is_unsigned), .deq_imm(deq_imm), .deq_src1(deq_src1),
      .deq_src2(deq_src2), .deq_ls_size(deq_ls_size),
      .deq_robidx_flag(deq_robidx_flag), .deq_robidx(deq_robidx),
      .flush_valid(flush_valid), .flush_robidx_flag(flush_robidx_flag),
      .flush_robidx(flush_robidx), .count(count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic enq_one(input logic [4:0] r, input logic f);
      robidx = r;
      robidx_flag = f;
      imm = 32'h100 + 32'(r);
      enq_valid = 1'b1;
      tick();
      enq_valid = 1'b0;
      #1;
   endtask

   initial begin
      enq_valid = 0; deq_ready = 0; flush_valid = 0;
      flush_robidx_flag = 0; flush_robidx = '0;
      prd = 6'd7; is_load = 1; is_store = 0; is_unsigned = 0;
      imm = '0; src1 = 32'h11; src2 = 32'h22; ls_size = 2'd2;
      robidx_flag = 0; robidx = '0;

      tick();
      tick();
      check("reset_deq_valid", 32'(deq_valid), 0);
      check("reset_enq_ready", 32'(enq_ready), 1);
      check("reset_count", 32'(count), 0);
      reset = 1'b0;

      // Fill to full with the consumer stalled.
      for (int k = 1; k <= 4; k++) enq_one(5'(k), 1'b0);
      check("full_count", 32'(count), 4);
      check("full_enq_ready", 32'(enq_ready), 0);
      check("full_head_robidx", 32'(deq_robidx), 1);
      check("full_head_imm", deq_imm, 32'h101);
      check("full_head_src2", deq_src2, 32'h22);
      enq_one(5'd5, 1'b0);
      check("fifth_rejected_count", 32'(count), 4);

      deq_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         check("drain_valid", 32'(deq_valid), 1);
         check("drain_robidx", 32'(deq_robidx), 32'(k));
         tick();
      end
      deq_ready = 1'b0;
      #1;
      check("drain_empty_valid", 32'(deq_valid), 0);
      check("drain_empty_count", 32'(count), 0);

      // Flush at 5 keeps 5, kills 6 and 7, drops the same-cycle enqueue of 8.
      enq_one(5'd5, 1'b0);
      enq_one(5'd6, 1'b0);
      enq_one(5'd7, 1'b0);
      flush_valid = 1; flush_robidx = 5'd5; flush_robidx_flag = 0;
      robidx = 5'd8; enq_valid = 1;
      tick();
      flush_valid = 0; enq_valid = 0;
      #1;
      check("flush1_count", 32'(count), 1);
      check("flush1_head", 32'(deq_robidx), 5);
      deq_ready = 1; tick(); deq_ready = 0; #1;
      check("flush1_after_deq_count", 32'(count), 0);
      enq_one(5'd9, 1'b0);
      check("flush1_tail_valid", 32'(deq_valid), 1);
      check("flush1_tail_robidx", 32'(deq_robidx), 9);
      deq_ready = 1; tick(); deq_ready = 0; #1;

      // Move head to slot 3, then straddle the wrap.
      enq_one(5'd10, 1'b0);
      deq_ready = 1; tick(); deq_ready = 0; #1;
      enq_one(5'd30, 1'b1);
      enq_one(5'd1, 1'b0);
      check("wrap_count_pre", 32'(count), 2);
      flush_valid = 1; flush_robidx = 5'd31; flush_robidx_flag = 1;
      tick();
      flush_valid = 0; #1;
      check("wrap_count", 32'(count), 1);
      check("wrap_head_robidx", 32'(deq_robidx), 30);
      check("wrap_head_flag", 32'(deq_robidx_flag), 1);

      // Flush with a same-cycle dequeue of the surviving head.
      enq_one(5'd2, 1'b0);
      enq_one(5'd3, 1'b0);
      check("fdeq_count_pre", 32'(count), 3);
      flush_valid = 1; flush_robidx = 5'd2; flush_robidx_flag = 0; deq_ready = 1;
      #1;
      check("fdeq_head_valid", 32'(deq_valid), 1);
      tick();
      flush_valid = 0; deq_ready = 0; #1;
      check("fdeq_count", 32'(count), 1);
      check("fdeq_head_robidx", 32'(deq_robidx), 2);

      // A killed head is hidden in the flush cycle.
      flush_valid = 1; flush_robidx = 5'd1; flush_robidx_flag = 0; deq_ready = 1;
      #1;
      check("killed_head_hidden", 32'(deq_valid), 0);
      tick();
      flush_valid = 0; deq_ready = 0; #1;
      check("killed_head_count", 32'(count), 0);

      // Asynchronous reset mid-operation.
      enq_one(5'd11, 1'b0);
      enq_one(5'd12, 1'b0);
      enq_one(5'd13, 1'b0);
      check("prereset_count", 32'(count), 3);
      check("prereset_valid", 32'(deq_valid), 1);
      #1;
      reset = 1'b1;
      #1;
      check("async_reset_valid", 32'(deq_valid), 0);
      check("async_reset_count", 32'(count), 0);
      check("async_reset_enq_ready", 32'(enq_ready), 1);
      tick();
      reset = 1'b0;
      enq_one(5'd14, 1'b0);
      check("post_reset_valid", 32'(deq_valid), 1);
      check("post_reset_robidx", 32'(deq_robidx), 14);
      check("post_reset_count", 32'(count), 1);
      deq_ready = 1; tick(); deq_ready = 0; #1;
      check("empty_before_latency", 32'(count), 0);

      // Enqueue-to-present latency from empty.
      robidx = 5'd15; robidx_flag = 0; enq_valid = 1; deq_ready = 1;
      #1;
`ifdef MEM_IQ_BYPASS_EN
      check("lat_same_cycle_valid", 32'(deq_valid), 1);
      check("lat_same_cycle_robidx", 32'(deq_robidx), 15);
`else
      check("lat_same_cycle_valid", 32'(deq_valid), 0);
`endif
      tick();
      enq_valid = 0; deq_ready = 0; #1;
`ifdef MEM_IQ_BYPASS_EN
      check("lat_next_count", 32'(count), 0);
      check("lat_next_valid", 32'(deq_valid), 0);
`else
      check("lat_next_count", 32'(count), 1);
      check("lat_next_valid", 32'(deq_valid), 1);
      check("lat_next_robidx", 32'(deq_robidx), 15);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_issue_queue.md
MEM_ISSUE_QUEUE -- requirements
Module: mem_issue_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of entries (power of two, at least 2).
REQ-002 The block SHALL have port clock, input, 1, the single clock.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have the enqueue handshake ports: enq_valid input 1, enq_ready output 1.
REQ-005 The block SHALL have enqueue payload inputs:
- prd `PREG_RANGE
- is_load 1, is_store 1, is_unsigned 1
- imm `SRC_RANGE, src1 `SRC_RANGE, src2 `SRC_RANGE
- ls_size `LS_SIZE_RANGE
- robidx_flag 1, robidx `ROB_SIZE_LOG
REQ-006 The block SHALL have the dequeue handshake ports: deq_valid output 1, deq_ready input 1, driven by the memory stage instr_ready.
REQ-007 The block SHALL have dequeue payload outputs deq_prd, deq_is_load, deq_is_store, deq_is_unsigned, deq_imm, deq_src1, deq_src2, deq_ls_size, deq_robidx_flag and deq_robidx, each the same width as its enqueue counterpart.
REQ-008 The block SHALL have flush inputs flush_valid 1, flush_robidx_flag 1, flush_robidx `ROB_SIZE_LOG.
REQ-009 The block SHALL have output count, width log2(DEPTH)+1, giving current occupancy.

Function
REQ-010 The block SHALL operate as an in-order FIFO of load/store micro-ops with head pointer, tail pointer and count registers; pointers wrap modulo DEPTH.
REQ-011 The block SHALL assert enq_ready = (count < DEPTH); an enqueue SHALL occur when enq_valid & enq_ready, writing the payload at tail, and tail increments.
REQ-012 The block SHALL assert deq_valid = (count != 0) & ~head_killed, where deq_* show the head entry; a dequeue SHALL occur when deq_valid & deq_ready, and head increments.
REQ-013 When full, an enqueue and a dequeue in the same cycle SHALL NOT both occur, because enq_ready is 0 from registered count.
REQ-014 Simultaneous enqueue and dequeue SHALL leave count unchanged.
REQ-015 An entry SHALL be killed when flush_valid and it is younger than the flush point, where younger means (flush_robidx_flag ^ entry_flag) ^ (flush_robidx < entry_robidx).
REQ-016 head_killed SHALL be the kill condition evaluated on the head entry in the current cycle, so a flushed head is never presented.
REQ-017 On flush, next count SHALL equal the number of contiguous unkilled entries from head, and tail SHALL become head + that number.
REQ-018 On flush, an enqueue in the same cycle SHALL be discarded.
REQ-019 On flush, a dequeue of an unkilled head in the same cycle SHALL still complete and SHALL be subtracted from the retained count.
REQ-020 Payload registers SHALL need no reset; only valid state (head, tail, count) is reset.

Reset
REQ-021 On reset assertion, head, tail and count SHALL clear to 0 asynchronously, giving deq_valid=0, enq_ready=1 and count=0.
REQ-022 A reset asserted mid-operation SHALL discard all entries; there SHALL be no partial-state retention.

Configuration
REQ-023 With MEM_IQ_BYPASS_EN defined, when count==0 and enq_valid and no flush of the incoming op, the incoming op SHALL drive deq_* and deq_valid combinationally; if deq_ready, it SHALL NOT be written, giving 0-cycle latency.
REQ-024 Without MEM_IQ_BYPASS_EN, enqueue-to-deq_valid latency SHALL be exactly 1 cycle, with no combinational path from enq_* to deq_*.

Verification
REQ-025 Scenario: reset, then enqueue robidx 1,2,3,4 with deq_ready=0 -> count=4, enq_ready=0; a 5th enq_valid is not accepted.
REQ-026 Scenario: full queue, deq_ready=1 for 4 cycles -> deq_robidx sequence 1,2,3,4, then deq_valid=0 and count=0.
REQ-027 Scenario: entries robidx 5,6,7 with flag 0, flush_valid with flush_robidx=5, flag 0 -> count=1 next cycle, head robidx 5 retained, tail=head+1.
REQ-028 Scenario: wrap case, head at 3 holding robidx 30 (flag 1) and 1 (flag 0), flush robidx 31 flag 1 -> entry 30 kept, entry 1 killed, count=1.
REQ-029 Scenario: reset asserted while count=3 and deq_valid=1 -> same-cycle deq_valid=0 and count=0; the first enqueue after release appears at head.
REQ-030 Scenario: enqueue into an empty queue with deq_ready=1 -> deq_valid in the same cycle with MEM_IQ_BYPASS_EN and count stays 0; the next cycle without it.
